seven_segment_mux: RTL

//  Parametrised, time-multiplexed hex driver for a common-anode 7-segment display bank.
//  - Latches a DIGITS-nibble value on a load strobe.
//  - Scans one digit per slot, with per-digit decimal points, per-digit blanking and 16-level PWM brightness.
//  - Sits between user logic and the board anode/segment/dp pins.
//  - Replaces the fixed 4-digit, always-full-brightness, dp-tied-off display driver.

---
 rtl/seven_segment_mux.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed hex driver for a common-anode 7-segment bank with
// per-digit dp/blanking and 16-level PWM. Optional macro: LEADING_ZERO_BLANK_EN.
`default_nettype none

module seven_segment_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segment,
  output logic                  dp,
  output logic                  digit_tick
);

  localparam int SUB_DIV = REFRESH_DIV / 16;
  localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_POL = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_POL   = {7{ACTIVE_LOW}};

  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] number_q;
  logic [DIGITS-1:0]   dp_q, blank_q;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          segment_q, segment_d;
  logic                dp_q_o, dp_d;
  logic                tick_q, tick_d;
  logic                sub_end, scan_adv, digit_on;
  logic [3:0]          nibble;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   suppress;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    suppress = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (number_q[4*i +: 4] == 4'h0);
      suppress[i] = zero_run;
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    sub_end  = (sub_q == SUB_LAST);
    scan_adv = sub_end && (pwm_q == 4'hF);
    sub_d    = sub_end ? '0 : sub_q + 1'b1;
    pwm_d    = sub_end ? pwm_q + 1'b1 : pwm_q;
    idx_d    = idx_q;
    if (scan_adv) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    nibble = number_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0: seg_raw = 7'h3F;
      4'h1: seg_raw = 7'h06;
      4'h2: seg_raw = 7'h5B;
      4'h3: seg_raw = 7'h4F;
      4'h4: seg_raw = 7'h66;
      4'h5: seg_raw = 7'h6D;
      4'h6: seg_raw = 7'h7D;
      4'h7: seg_raw = 7'h07;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h6F;
      4'hA: seg_raw = 7'h77;
      4'hB: seg_raw = 7'h7C;
      4'hC: seg_raw = 7'h39;
      4'hD: seg_raw = 7'h5E;
      4'hE: seg_raw = 7'h79;
      default: seg_raw = 7'h71;
    endcase
    digit_on  = (pwm_q <= brightness) && !blank_q[idx_q] && !suppress[idx_q];
    anode_d   = (digit_on ? (DIGITS'(1) << idx_q) : '0) ^ ANODE_POL;
    segment_d = seg_raw ^ SEG_POL;
    dp_d      = (dp_q[idx_q] & ~suppress[idx_q]) ^ ACTIVE_LOW;
    tick_d    = scan_adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q     <= '0;
      pwm_q     <= '0;
      idx_q     <= '0;
      number_q  <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      anode_q   <= ANODE_POL;
      segment_q <= SEG_POL;
      dp_q_o    <= ACTIVE_LOW;
      tick_q    <= 1'b0;
    end else begin
      sub_q     <= sub_d;
      pwm_q     <= pwm_d;
      idx_q     <= idx_d;
      if (load) begin
        number_q <= number;
        dp_q     <= dp_in;
        blank_q  <= blank;
      end
      anode_q   <= anode_d;
      segment_q <= segment_d;
      dp_q_o    <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = segment_q;
  assign dp         = dp_q_o;
  assign digit_tick = tick_q;

endmodule

`default_nettype wire
